// File: rtl/apb_interconnect_pkg.sv
// Shared definitions for the APB3 single-master interconnect: FSM state encoding,
// the default slave-map field position and the timeout counter width helper.
package apb_interconnect_pkg;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } apb_state_t;

   // Default slave map: 4 KiB windows, slave index starts at PADDR[12].
   localparam int DEF_SEL_LSB = 12;

   function automatic int cnt_width(input int max_cyc);
      return (max_cyc <= 1) ? 1 : $clog2(max_cyc + 1);
   endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// Saturating ACCESS-phase wait counter; hit flags the last permitted wait cycle.
// MAX_CYC = 0 disables the timeout (hit never asserts).
module apb_timeout_cnt
   import apb_interconnect_pkg::*;
#(
   parameter int MAX_CYC = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic hit
);

   localparam int W = cnt_width(MAX_CYC);
   localparam logic [W-1:0] HIT_VAL = (MAX_CYC == 0) ? '0 : W'(MAX_CYC - 1);
   localparam logic [W-1:0] SAT_VAL = '1;

   logic [W-1:0] cnt;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && (cnt != SAT_VAL)) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign hit = (MAX_CYC != 0) && (cnt == HIT_VAL);

endmodule

// File: rtl/apb_interconnect.sv
// APB3 single-master / NUM_SLAVES-slave interconnect with decode-error and
// wait-state timeout responses. Optional error log enabled by APB_ERR_LOG_EN.
module apb_interconnect
   import apb_interconnect_pkg::*;
#(
   parameter int NUM_SLAVES  = 3,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int SEL_LSB     = DEF_SEL_LSB,
   parameter int SEL_W       = 2,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       m_psel,
   input  logic                       m_penable,
   input  logic                       m_pwrite,
   input  logic [ADDR_W-1:0]          m_paddr,
   input  logic [DATA_W-1:0]          m_pwdata,
   output logic [DATA_W-1:0]          m_prdata,
   output logic                       m_pready,
   output logic                       m_pslverr,
   output logic [NUM_SLAVES-1:0]      s_psel,
   output logic                       s_penable,
   output logic                       s_pwrite,
   output logic [ADDR_W-1:0]          s_paddr,
   output logic [DATA_W-1:0]          s_pwdata,
   input  logic [NUM_SLAVES*DATA_W-1:0] s_prdata,
   input  logic [NUM_SLAVES-1:0]      s_pready,
   input  logic [NUM_SLAVES-1:0]      s_pslverr
`ifdef APB_ERR_LOG_EN
   ,
   input  logic                       err_clr,
   output logic                       err_valid,
   output logic [ADDR_W-1:0]          err_addr,
   output logic                       err_is_to,
   output logic [7:0]                 err_cnt
`endif
);

   apb_state_t        state, state_nx;
   logic [SEL_W-1:0]  dec_idx, idx_q;
   logic              dec_err, err_q;
   logic              setup;
   logic              sel_pready, sel_pslverr;
   logic [DATA_W-1:0] sel_prdata;
   logic              tmo_hit, to_hit;
   logic              cnt_clr, cnt_en;
   logic [NUM_SLAVES-1:0] psel_c;
   logic              pready_c, pslverr_c;
   logic [DATA_W-1:0] prdata_c;

   assign dec_idx = m_paddr[SEL_LSB +: SEL_W];
   assign dec_err = int'(dec_idx) >= NUM_SLAVES;
   assign setup   = m_psel & ~m_penable;

   // Loop mux keeps out-of-range idx_q (decode errors) from indexing past the ports.
   // NOTE: every variable driven in always_comb gets a default first, otherwise an
   // unassigned path would infer a latch.
   always_comb begin
      sel_pready  = 1'b0;
      sel_pslverr = 1'b0;
      sel_prdata  = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (idx_q == SEL_W'(i)) begin
            sel_pready  = s_pready[i];
            sel_pslverr = s_pslverr[i];
            sel_prdata  = s_prdata[i*DATA_W +: DATA_W];
         end
      end
   end

   assign to_hit = (state == ST_ACCESS) & ~err_q & tmo_hit & ~sel_pready;

   always_comb begin
      state_nx  = state;
      psel_c    = '0;
      pready_c  = 1'b0;
      pslverr_c = 1'b0;
      prdata_c  = '0;
      cnt_clr   = 1'b0;
      cnt_en    = 1'b0;
      case (state)
         ST_IDLE: begin
            for (int i = 0; i < NUM_SLAVES; i++) begin
               psel_c[i] = setup & ~dec_err & (dec_idx == SEL_W'(i));
            end
            cnt_clr = 1'b1;
            if (setup) begin
               state_nx = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            for (int i = 0; i < NUM_SLAVES; i++) begin
               psel_c[i] = m_psel & ~err_q & ~to_hit & (idx_q == SEL_W'(i));
            end
            if (err_q || to_hit) begin
               pready_c  = 1'b1;
               pslverr_c = 1'b1;
            end else begin
               pready_c  = sel_pready;
               pslverr_c = sel_pready & sel_pslverr;
               prdata_c  = sel_pready ? sel_prdata : '0;
            end
            if (pready_c || !m_psel) begin
               state_nx = ST_IDLE;
               cnt_clr  = 1'b1;
            end else begin
               cnt_en = 1'b1;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         idx_q <= '0;
         err_q <= 1'b0;
      end else begin
         state <= state_nx;
         if ((state == ST_IDLE) && setup) begin
            idx_q <= dec_idx;
            err_q <= dec_err;
         end
      end
   end

   apb_timeout_cnt #(
      .MAX_CYC (TIMEOUT_CYC)
   ) u_timeout_cnt (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .en  (cnt_en),
      .hit (tmo_hit)
   );

   // Reset gates the handshake outputs combinationally, before the FSM has seen an edge.
   assign s_psel    = rst ? '0 : psel_c;
   assign s_penable = ~rst & m_penable & (|psel_c);
   assign m_pready  = ~rst & pready_c;
   assign m_pslverr = ~rst & pslverr_c;
   assign m_prdata  = rst ? '0 : prdata_c;

   assign s_pwrite = m_pwrite;
   assign s_paddr  = m_paddr;
   assign s_pwdata = m_pwdata;

`ifdef APB_ERR_LOG_EN
   logic              err_evt;
   logic              valid_b;
   logic [7:0]        cnt_b;
   logic [ADDR_W-1:0] addr_b;
   logic              is_to_b;

   assign err_evt = m_pready & m_pslverr;

   // Clear applies first so an error in the clear cycle still lands in the log.
   always_comb begin
      valid_b = err_valid & ~err_clr;
      cnt_b   = err_clr ? 8'd0 : err_cnt;
      addr_b  = err_clr ? '0 : err_addr;
      is_to_b = err_is_to & ~err_clr;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_valid <= 1'b0;
         err_cnt   <= 8'd0;
         err_addr  <= '0;
         err_is_to <= 1'b0;
      end else begin
         err_valid <= valid_b | err_evt;
         err_cnt   <= (err_evt && (cnt_b != 8'hFF)) ? cnt_b + 8'd1 : cnt_b;
         if (err_evt && !valid_b) begin
            err_addr  <= m_paddr;
            err_is_to <= to_hit;
         end else begin
            err_addr  <= addr_b;
            err_is_to <= is_to_b;
         end
      end
   end
`endif

endmodule

// File: tb/tb_apb_interconnect.sv
// Directed bench for apb_interconnect: expected responses are queued by the master
// tasks and popped by an independent monitor whenever m_pready is seen.
module tb_apb_interconnect;

   localparam int NS = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          m_psel = 1'b0, m_penable = 1'b0, m_pwrite = 1'b0;
   logic [31:0]   m_paddr = '0, m_pwdata = '0;
   logic [31:0]   m_prdata;
   logic          m_pready, m_pslverr;
   logic [NS-1:0] s_psel;
   logic          s_penable, s_pwrite;
   logic [31:0]   s_paddr, s_pwdata;
   logic [NS*32-1:0] s_prdata;
   logic [NS-1:0] s_pready, s_pslverr;
   logic          err_clr = 1'b0;
`ifdef APB_ERR_LOG_EN
   logic          err_valid, err_is_to;
   logic [31:0]   err_addr;
   logic [7:0]    err_cnt;
`endif

   apb_interconnect dut (
      .clk       (clk),
      .rst       (rst),
      .m_psel    (m_psel),
      .m_penable (m_penable),
      .m_pwrite  (m_pwrite),
      .m_paddr   (m_paddr),
      .m_pwdata  (m_pwdata),
      .m_prdata  (m_prdata),
      .m_pready  (m_pready),
      .m_pslverr (m_pslverr),
      .s_psel    (s_psel),
      .s_penable (s_penable),
      .s_pwrite  (s_pwrite),
      .s_paddr   (s_paddr),
      .s_pwdata  (s_pwdata),
      .s_prdata  (s_prdata),
      .s_pready  (s_pready),
      .s_pslverr (s_pslverr)
`ifdef APB_ERR_LOG_EN
      ,
      .err_clr   (err_clr),
      .err_valid (err_valid),
      .err_addr  (err_addr),
      .err_is_to (err_is_to),
      .err_cnt   (err_cnt)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } exp_t;
   exp_t exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Slave models: fixed wait states counted from the first ACCESS cycle,
   // ready derived from registers only so there is no loop through the DUT.
   logic [7:0]    wait_cfg  [NS];
   logic [31:0]   rdata_cfg [NS];
   logic          err_cfg   [NS];
   logic [7:0]    wcnt      [NS];
   logic [NS-1:0] sel_q;

   always @(posedge clk) begin
      for (int i = 0; i < NS; i++) begin
         if (rst) begin
            wcnt[i]  <= 8'd0;
            sel_q[i] <= 1'b0;
         end else begin
            sel_q[i] <= s_psel[i] & (~s_penable | ~s_pready[i]);
            wcnt[i]  <= (s_psel[i] & s_penable & ~s_pready[i]) ? wcnt[i] + 8'd1 : 8'd0;
         end
      end
   end

   always_comb begin
      s_pready  = '0;
      s_pslverr = '0;
      s_prdata  = '0;
      for (int i = 0; i < NS; i++) begin
         s_pready[i]          = sel_q[i] & (wcnt[i] >= wait_cfg[i]);
         s_pslverr[i]         = err_cfg[i];
         s_prdata[i*32 +: 32] = rdata_cfg[i];
      end
   end

   // Monitor: every completion the master sees must match the oldest queued expectation.
   always @(negedge clk) begin
      if (!rst && m_pready) begin
         if (exp_q.size() == 0) begin
            check("sb_unexpected_ready", 1, 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("sb_prdata", m_prdata, e.rdata);
            check("sb_pslverr", m_pslverr, e.err);
         end
      end
   end

   task automatic apb_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                           input logic [NS-1:0] exp_sel, input logic [NS-1:0] exp_done_sel,
                           input logic [31:0] exp_rdata, input logic exp_err,
                           input int exp_cyc, output int ncyc);
      logic done;
      exp_q.push_back('{rdata: exp_rdata, err: exp_err});
      @(posedge clk); #1;
      m_psel = 1'b1; m_penable = 1'b0; m_pwrite = wr; m_paddr = addr; m_pwdata = wdata;
      @(negedge clk);
      check("setup_sel", s_psel, exp_sel);
      check("setup_penable", s_penable, 0);
      check("setup_pass", {s_paddr, s_pwdata}, {addr, wdata});
      ncyc = 1;
      done = 1'b0;
      @(posedge clk); #1;
      m_penable = 1'b1;
      for (int k = 0; k < 40 && !done; k++) begin
         @(negedge clk);
         ncyc++;
         if (k == 0) begin
            check("access_sel", s_psel, exp_sel);
            check("access_penable", s_penable, |exp_sel);
         end
         if (m_pready) done = 1'b1;
         else begin
            @(posedge clk); #1;
         end
      end
      if (!done) check("xfer_ready_timeout", 0, 1);
      else check("done_sel", s_psel, exp_done_sel);
      check("xfer_cycles", ncyc, exp_cyc);
   endtask

   task automatic idle();
      @(posedge clk); #1;
      m_psel = 1'b0; m_penable = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n, n2;
      for (int i = 0; i < NS; i++) begin
         wait_cfg[i] = 8'd0; rdata_cfg[i] = 32'h0; err_cfg[i] = 1'b0;
      end

      // Reset with a setup cycle presented: everything must stay quiet.
      m_psel = 1'b1; m_paddr = 32'h0000_1000;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_s_psel", s_psel, 0);
      check("rst_outputs", {s_penable, m_pready, m_pslverr}, 0);
      check("rst_prdata", m_prdata, 0);
      @(posedge clk); #1;
      rst = 1'b0; m_psel = 1'b0;

      // Read slave 1 with two wait states.
      wait_cfg[1] = 8'd2; rdata_cfg[1] = 32'hDEAD_BEEF;
      apb_xfer(32'h0000_1004, 1'b0, 32'h0, 3'b010, 3'b010, 32'hDEAD_BEEF, 1'b0, 4, n);
      idle();

      // Decode error: index 3 with three slaves.
      apb_xfer(32'h0000_3000, 1'b1, 32'h5555_AAAA, 3'b000, 3'b000, 32'h0, 1'b1, 2, n);
      idle();

      // Slave 0 never ready: abort on 16th ACCESS cycle, then penable alone is ignored.
      wait_cfg[0] = 8'd255; rdata_cfg[0] = 32'h0BAD_0BAD;
      apb_xfer(32'h0000_0000, 1'b0, 32'h0, 3'b001, 3'b000, 32'h0, 1'b1, 17, n);
      @(posedge clk); #1;
      @(negedge clk);
      check("post_to_idle_sel", s_psel, 0);
      check("post_to_idle_ready", {s_penable, m_pready}, 0);
      idle();

      // Back-to-back: slave 2 write then slave 0 read, no wait states.
      wait_cfg[0] = 8'd0; rdata_cfg[0] = 32'hA5A5_0000;
      wait_cfg[2] = 8'd0; rdata_cfg[2] = 32'h2222_2222;
      apb_xfer(32'h0000_2000, 1'b1, 32'h1234_0002, 3'b100, 3'b100, 32'h2222_2222, 1'b0, 2, n);
      apb_xfer(32'h0000_0008, 1'b0, 32'h0, 3'b001, 3'b001, 32'hA5A5_0000, 1'b0, 2, n2);
      check("b2b_total_cycles", n + n2, 4);
      idle();

      // Slave-reported error with one wait state.
      wait_cfg[2] = 8'd1; rdata_cfg[2] = 32'hCAFE_F00D; err_cfg[2] = 1'b1;
      apb_xfer(32'h0000_200C, 1'b0, 32'h0, 3'b100, 3'b100, 32'hCAFE_F00D, 1'b1, 3, n);
      idle();
      err_cfg[2] = 1'b0;

      // Reset during a slave 1 wait state while that slave is already ready.
      wait_cfg[1] = 8'd1; rdata_cfg[1] = 32'h1111_0000;
      @(posedge clk); #1;
      m_psel = 1'b1; m_penable = 1'b0; m_pwrite = 1'b0; m_paddr = 32'h0000_1008;
      @(negedge clk);
      check("rstmid_setup_sel", s_psel, 3'b010);
      @(posedge clk); #1;
      m_penable = 1'b1;
      @(negedge clk);
      check("rstmid_wait", m_pready, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check("rstmid_in_ready", s_pready[1], 1);
      check("rstmid_s_psel", s_psel, 0);
      check("rstmid_outputs", {s_penable, m_pready, m_pslverr}, 0);
      @(posedge clk); #1;
      rst = 1'b0; m_psel = 1'b0; m_penable = 1'b0;
      @(negedge clk);
      check("rstmid_idle", {s_psel, m_pready}, 0);

      wait_cfg[1] = 8'd1; rdata_cfg[1] = 32'h1234_5678;
      apb_xfer(32'h0000_1010, 1'b0, 32'h0, 3'b010, 3'b010, 32'h1234_5678, 1'b0, 3, n);
      idle();

`ifdef APB_ERR_LOG_EN
      @(negedge clk);
      check("log_reset", {err_valid, err_is_to, err_cnt}, 0);
      apb_xfer(32'h0000_3010, 1'b0, 32'h0, 3'b000, 3'b000, 32'h0, 1'b1, 2, n);
      idle();
      wait_cfg[0] = 8'd255;
      apb_xfer(32'h0000_0010, 1'b0, 32'h0, 3'b001, 3'b000, 32'h0, 1'b1, 17, n);
      idle();
      @(negedge clk);
      check("log_valid", err_valid, 1);
      check("log_addr", err_addr, 32'h0000_3010);
      check("log_is_to", err_is_to, 0);
      check("log_cnt", err_cnt, 2);
      @(posedge clk); #1;
      err_clr = 1'b1;
      @(posedge clk); #1;
      err_clr = 1'b0;
      @(negedge clk);
      check("log_clr", {err_valid, err_is_to, err_addr, err_cnt}, 0);
`endif

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("sb_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
